// File: rtl/rtype_pkg.sv
// Shared definitions for the pipelined R-type datapath: instruction field
// positions, funct codes, ALU operation enum and the decoder.
package rtype_pkg;

    localparam int REG_AW = 5;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SH_MSB = 10;
    localparam int SH_LSB = 6;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_ILL
    } alu_op_t;

    function automatic alu_op_t decode_op(input logic [5:0] op, input logic [5:0] funct);
        alu_op_t res;
        res = ALU_ILL;
        if (op == 6'h00) begin
            case (funct)
                FN_ADD:  res = ALU_ADD;
                FN_SUB:  res = ALU_SUB;
                FN_AND:  res = ALU_AND;
                FN_OR:   res = ALU_OR;
                FN_NOR:  res = ALU_NOR;
                FN_SLT:  res = ALU_SLT;
                FN_SLL:  res = ALU_SLL;
                FN_SRL:  res = ALU_SRL;
                default: res = ALU_ILL;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/rtype_pipe_if.sv
// Instruction-feed, writeback and debug-read bundle of rtype_pipe.
// The master drives instructions and debug addresses; the slave is the pipe.
interface rtype_pipe_if #(parameter int DATA_W = 32);
    import rtype_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ovf;
    logic              wb_illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_valid, instr, dbg_addr,
        input  instr_ready, wb_valid, wb_addr, wb_data, wb_ovf, wb_illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instr, dbg_addr,
        output instr_ready, wb_valid, wb_addr, wb_data, wb_ovf, wb_illegal, dbg_data
    );

endinterface

// File: rtl/rtype_alu.sv
// Combinational R-type ALU. Illegal ops produce result 0 and no overflow;
// shifts by DATA_W or more produce 0.
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        shamt_i,
    input  alu_op_t           op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              big_shift;
    logic              lt;

    assign sum       = a_i + b_i;
    assign diff      = a_i - b_i;
    assign big_shift = int'(shamt_i) >= DATA_W;
    assign lt        = $signed(a_i) < $signed(b_i);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch inferred.
        result_o = '0;
        ovf_o    = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, lt};
            ALU_SLL: result_o = big_shift ? '0 : (b_i << shamt_i);
            ALU_SRL: result_o = big_shift ? '0 : (b_i >> shamt_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/rtype_pipe.sv
// Three-stage (read / execute / writeback) R-type pipeline with register file.
// Define FORWARD_EN to bypass hazards from EX/WB; otherwise dependents stall.
module rtype_pipe
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    rtype_pipe_if.slave bus
);

    localparam int IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

    function automatic logic writable(input logic [REG_AW-1:0] addr);
        return (addr != '0) && (int'(addr) < REG_N);
    endfunction

    logic [REG_AW-1:0] rs, rt, rd;
    logic [4:0]        shamt;
    alu_op_t           dec_op;

    assign rs     = bus.instr[RS_MSB:RS_LSB];
    assign rt     = bus.instr[RT_MSB:RT_LSB];
    assign rd     = bus.instr[RD_MSB:RD_LSB];
    assign shamt  = bus.instr[SH_MSB:SH_LSB];
    assign dec_op = decode_op(bus.instr[OP_MSB:OP_LSB], bus.instr[FN_MSB:FN_LSB]);

    logic [DATA_W-1:0] rf_q [REG_N];

    logic              ex_valid_q;
    alu_op_t           ex_op_q;
    logic [DATA_W-1:0] ex_a_q, ex_b_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic [4:0]        ex_shamt_q;

    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_ovf_q, wb_ill_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (ex_a_q),
        .b_i      (ex_b_q),
        .shamt_i  (ex_shamt_q),
        .op_i     (ex_op_q),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    // Only legal, valid instructions with a real destination can feed a hazard.
    logic ex_hz, wb_hz;
    assign ex_hz = ex_valid_q && (ex_op_q != ALU_ILL) && writable(ex_rd_q);
    assign wb_hz = wb_valid_q && !wb_ill_q && writable(wb_addr_q);

    logic [DATA_W-1:0] rf_rs, rf_rt;
    assign rf_rs = writable(rs) ? rf_q[rs[IDX_W-1:0]] : '0;
    assign rf_rt = writable(rt) ? rf_q[rt[IDX_W-1:0]] : '0;

    logic [DATA_W-1:0] ex_a_d, ex_b_d;
    logic              stall;

`ifdef FORWARD_EN
    always_comb begin
        ex_a_d = rf_rs;
        ex_b_d = rf_rt;
        if (ex_hz && (ex_rd_q == rs))        ex_a_d = alu_res;
        else if (wb_hz && (wb_addr_q == rs)) ex_a_d = wb_data_q;
        if (ex_hz && (ex_rd_q == rt))        ex_b_d = alu_res;
        else if (wb_hz && (wb_addr_q == rt)) ex_b_d = wb_data_q;
    end
    assign stall = 1'b0;
`else
    assign ex_a_d = rf_rs;
    assign ex_b_d = rf_rt;
    assign stall  = bus.instr_valid &&
                    ((ex_hz && ((ex_rd_q == rs) || (ex_rd_q == rt))) ||
                     (wb_hz && ((wb_addr_q == rs) || (wb_addr_q == rt))));
`endif

    logic accept;
    assign bus.instr_ready = !stall;
    assign accept          = bus.instr_valid && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= ALU_ADD;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rd_q    <= '0;
            ex_shamt_q <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_ovf_q   <= 1'b0;
            wb_ill_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so WB captures the EX contents from before this edge.
            ex_valid_q <= accept;
            if (accept) begin
                ex_op_q    <= dec_op;
                ex_a_q     <= ex_a_d;
                ex_b_q     <= ex_b_d;
                ex_rd_q    <= rd;
                ex_shamt_q <= shamt;
            end
            wb_valid_q <= ex_valid_q;
            wb_addr_q  <= ex_valid_q ? ex_rd_q : '0;
            wb_data_q  <= ex_valid_q ? alu_res : '0;
            wb_ovf_q   <= ex_valid_q && alu_ovf;
            wb_ill_q   <= ex_valid_q && (ex_op_q == ALU_ILL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is flop-based and must read zero after reset, so it is reset.
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else if (wb_hz) begin
            rf_q[wb_addr_q[IDX_W-1:0]] <= wb_data_q;
        end
    end

    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_ovf     = wb_ovf_q;
    assign bus.wb_illegal = wb_ill_q;
    assign bus.dbg_data   = writable(bus.dbg_addr) ? rf_q[bus.dbg_addr[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_rtype_pipe.sv
// Scoreboard bench for rtype_pipe (DATA_W=32, REG_N=8): directed stimulus pushes
// expected retirements; a negedge monitor pops and compares them.
module tb_rtype_pipe;

    localparam int DATA_W = 32;
    localparam int REG_N  = 8;
`ifdef FORWARD_EN
    localparam int EXP_STALL = 0;
    localparam int EXP_GAP   = 1;
`else
    localparam int EXP_STALL = 2;
    localparam int EXP_GAP   = 3;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtype_pipe_if #(.DATA_W(DATA_W)) bus ();

    rtype_pipe #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   ret_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wb_valid) begin
                ret_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wb: got addr %0d data 0x%0h with nothing expected",
                             bus.wb_addr, bus.wb_data);
                end else begin
                    e = sb.pop_front();
                    check("wb", 64'({bus.wb_addr, bus.wb_data, bus.wb_ovf, bus.wb_illegal}), 64'(e));
                end
            end
        end
    end

    function automatic logic [31:0] r(input logic [5:0] fn, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    // Presents ins until accepted; w counts the cycles instr_ready was low.
    task automatic issue(input logic [31:0] ins, input logic [31:0] ed, input logic eo,
                         input logic ei, input bit push, output int w);
        exp_t e;
        e = '{addr: ins[15:11], data: ed, ovf: eo, ill: ei};
        w = 0;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        #1;
        while (bus.instr_ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (bus.instr_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: instr 0x%08h never accepted", ins);
        end else begin
            if (push) sb.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
    endtask

    task automatic go(input logic [31:0] ins, input logic [31:0] ed, input logic eo,
                      input logic ei, output int w);
        issue(ins, ed, eo, ei, 1'b1, w);
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp, input string name);
        bus.dbg_addr = a;
        #1;
        check(name, 64'(bus.dbg_data), 64'(exp));
    endtask

    task automatic check_gaps(input string name, input int n, input int gap);
        check({name, "_nret"}, 64'(ret_cyc.size()), 64'(n));
        if (ret_cyc.size() == n)
            for (int i = 1; i < n; i++)
                check({name, "_gap"}, 64'(ret_cyc[i] - ret_cyc[i-1]), 64'(gap));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, w1, w2, w3;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.dbg_addr    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_data", 64'(bus.wb_data), 64'd0);
        check("rst_ready", 64'(bus.instr_ready), 64'd1);
        dbg(5'd1, 32'h0, "rst_dbg_r1");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Build constants from r0: r1=5, r2=7.
        go(r(6'h27, 5'd1, 5'd0, 5'd0, 5'd0), 32'hFFFF_FFFF, 1'b0, 1'b0, w0);
        go(r(6'h22, 5'd2, 5'd0, 5'd1, 5'd0), 32'd1, 1'b0, 1'b0, w0);
        go(r(6'h00, 5'd3, 5'd0, 5'd2, 5'd2), 32'd4, 1'b0, 1'b0, w0);
        go(r(6'h00, 5'd4, 5'd0, 5'd2, 5'd1), 32'd2, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd5, 5'd3, 5'd2, 5'd0), 32'd5, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd6, 5'd4, 5'd2, 5'd0), 32'd3, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd7, 5'd6, 5'd3, 5'd0), 32'd7, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd1, 5'd5, 5'd0, 5'd0), 32'd5, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd2, 5'd7, 5'd0, 5'd0), 32'd7, 1'b0, 1'b0, w0);
        drain();
        dbg(5'd1, 32'd5, "setup_r1");
        dbg(5'd2, 32'd7, "setup_r2");

        // Independent back-to-back stream.
        ret_cyc.delete();
        go(r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), 32'd12, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd4, 5'd1, 5'd2, 5'd0), 32'd7, 1'b0, 1'b0, w1);
        drain();
        check("indep_ready_low", 64'(w0 + w1), 64'd0);
        check_gaps("indep", 2, 1);

        // Back-to-back RAW chain.
        ret_cyc.delete();
        go(r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), 32'd12, 1'b0, 1'b0, w0);
        go(r(6'h22, 5'd5, 5'd3, 5'd1, 5'd0), 32'd7, 1'b0, 1'b0, w1);
        go(r(6'h24, 5'd6, 5'd3, 5'd5, 5'd0), 32'd4, 1'b0, 1'b0, w2);
        drain();
        check("dep_stall_sub", 64'(w1), 64'(EXP_STALL));
        check("dep_stall_and", 64'(w2), 64'(EXP_STALL));
        check_gaps("dep", 3, EXP_GAP);

        // Arithmetic edges.
        go(r(6'h27, 5'd7, 5'd0, 5'd0, 5'd0), 32'hFFFF_FFFF, 1'b0, 1'b0, w0);
        go(r(6'h02, 5'd6, 5'd0, 5'd7, 5'd1), 32'h7FFF_FFFF, 1'b0, 1'b0, w0);
        go(r(6'h22, 5'd4, 5'd0, 5'd7, 5'd0), 32'd1, 1'b0, 1'b0, w0);
        go(r(6'h20, 5'd5, 5'd6, 5'd4, 5'd0), 32'h8000_0000, 1'b1, 1'b0, w0);
        go(r(6'h2A, 5'd3, 5'd7, 5'd4, 5'd0), 32'd1, 1'b0, 1'b0, w0);
        go(r(6'h00, 5'd2, 5'd0, 5'd4, 5'd31), 32'h8000_0000, 1'b0, 1'b0, w0);
        go(r(6'h22, 5'd1, 5'd5, 5'd4, 5'd0), 32'h7FFF_FFFF, 1'b1, 1'b0, w0);
        drain();

        // Register 0 and out-of-range destinations.
        go(r(6'h20, 5'd0, 5'd4, 5'd4, 5'd0), 32'd2, 1'b0, 1'b0, w0);
        go(r(6'h25, 5'd1, 5'd0, 5'd4, 5'd0), 32'd1, 1'b0, 1'b0, w1);
        go(r(6'h20, 5'd9, 5'd4, 5'd4, 5'd0), 32'd2, 1'b0, 1'b0, w2);
        go(r(6'h20, 5'd2, 5'd9, 5'd4, 5'd0), 32'd1, 1'b0, 1'b0, w3);
        drain();
        check("r0_follow_ready_low", 64'(w1), 64'd0);
        check("r9_follow_ready_low", 64'(w3), 64'd0);
        dbg(5'd0, 32'd0, "dbg_r0");
        dbg(5'd9, 32'd0, "dbg_r9");
        dbg(5'd1, 32'd1, "dbg_r1_after_r0_read");
        dbg(5'd2, 32'd1, "dbg_r2_after_r9_read");

        // Illegal op and illegal funct; dependents see old values.
        go({6'h23, 5'd4, 5'd4, 5'd2, 5'd0, 6'h20}, 32'd0, 1'b0, 1'b1, w0);
        go(r(6'h20, 5'd3, 5'd2, 5'd0, 5'd0), 32'd1, 1'b0, 1'b0, w1);
        go(r(6'h21, 5'd4, 5'd4, 5'd4, 5'd0), 32'd0, 1'b0, 1'b1, w0);
        go(r(6'h20, 5'd5, 5'd4, 5'd0, 5'd0), 32'd1, 1'b0, 1'b0, w2);
        drain();
        check("ill_follow_ready_low", 64'(w1 + w2), 64'd0);
        dbg(5'd2, 32'd1, "dbg_r2_after_ill");
        dbg(5'd4, 32'd1, "dbg_r4_after_ill");

        // Reset with two instructions in flight.
        issue(r(6'h20, 5'd6, 5'd4, 5'd4, 5'd0), 32'd2, 1'b0, 1'b0, 1'b0, w0);
        issue(r(6'h25, 5'd7, 5'd4, 5'd4, 5'd0), 32'd1, 1'b0, 1'b0, 1'b0, w0);
        check("pre_rst_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("pre_rst_wb_addr", 64'(bus.wb_addr), 64'd6);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wb", 64'({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.wb_ovf, bus.wb_illegal}), 64'd0);
        check("mid_rst_ready", 64'(bus.instr_ready), 64'd1);
        for (int i = 0; i < 32; i++) dbg(5'(i), 32'd0, "mid_rst_dbg");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_ready", 64'(bus.instr_ready), 64'd1);
        check("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        dbg(5'd6, 32'd0, "post_rst_r6");
        dbg(5'd7, 32'd0, "post_rst_r7");

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
